branch_predictor: RTL and testbench

//   Fetch-side partner of the EX-stage branch condition unit. Looks up the fetch PC in a

---
 rtl/branch_predictor_if.sv | 36 +++
 rtl/branch_predictor.sv | 137 +++++++++++++
 tb/tb_branch_predictor.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch/resolve port bundle of the branch predictor.
// master = pipeline side, slave = predictor.
interface branch_predictor_if #(
    parameter int CNT_W = 16
) ();
    logic [31:0]      i_pc;
    logic             o_pred_taken;
    logic [31:0]      o_pred_target;
    logic             i_res_valid;
    logic             i_res_is_branch;
    logic [31:0]      i_res_pc;
    logic             i_res_taken;
    logic [31:0]      i_res_target;
    logic             i_res_pred_taken;
    logic [31:0]      i_res_pred_target;
    logic             o_mispredict;
    logic [31:0]      o_redirect_pc;
    logic [CNT_W-1:0] o_branch_cnt;
    logic [CNT_W-1:0] o_miss_cnt;

    modport master (
        output i_pc, i_res_valid, i_res_is_branch, i_res_pc,
        output i_res_taken, i_res_target,
        output i_res_pred_taken, i_res_pred_target,
        input  o_pred_taken, o_pred_target, o_mispredict,
        input  o_redirect_pc, o_branch_cnt, o_miss_cnt
    );

    modport slave (
        input  i_pc, i_res_valid, i_res_is_branch, i_res_pc,
        input  i_res_taken, i_res_target,
        input  i_res_pred_taken, i_res_pred_target,
        output o_pred_taken, o_pred_target, o_mispredict,
        output o_redirect_pc, o_branch_cnt, o_miss_cnt
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters, resolve-time update
// and registered mispredict/redirect pulse.
module branch_predictor #(
    parameter int INDEX_W = 6,
    parameter int CNT_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    branch_predictor_if.slave bp
);
    localparam int N     = 1 << INDEX_W;
    localparam int TAG_W = 32 - INDEX_W - 2;

    logic             valid_q [N];
    logic             valid_d [N];
    logic [TAG_W-1:0] tag_q   [N];
    logic [TAG_W-1:0] tag_d   [N];
    logic [31:0]      tgt_q   [N];
    logic [31:0]      tgt_d   [N];
    logic [1:0]       ctr_q   [N];
    logic [1:0]       ctr_d   [N];

    logic             mispredict_q, mispredict_d;
    logic [31:0]      redirect_q, redirect_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic [INDEX_W-1:0] l_idx;
    logic [TAG_W-1:0]   l_tag;
    logic               l_hit;
    logic [INDEX_W-1:0] r_idx;
    logic [TAG_W-1:0]   r_tag;
    logic               r_hit;
    logic               res_br;
    logic               res_alias;
    logic               miss;
    logic [31:0]        act_next;

    assign l_idx = bp.i_pc[INDEX_W+1:2];
    assign l_tag = bp.i_pc[31:INDEX_W+2];
    assign r_idx = bp.i_res_pc[INDEX_W+1:2];
    assign r_tag = bp.i_res_pc[31:INDEX_W+2];

    // Fetch-side lookup; sees table state before any same-cycle update
    always_comb begin
        l_hit            = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
        bp.o_pred_taken  = l_hit && ctr_q[l_idx][1];
        bp.o_pred_target = bp.o_pred_taken ? tgt_q[l_idx]
                                           : bp.i_pc + 32'd4;
    end

    // Resolve: classify the retiring instruction and detect a miss
    always_comb begin
        r_hit     = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
        res_br    = bp.i_res_valid && bp.i_res_is_branch;
        res_alias = bp.i_res_valid && !bp.i_res_is_branch
                    && bp.i_res_pred_taken;
        act_next  = (res_br && bp.i_res_taken) ? bp.i_res_target
                                               : bp.i_res_pc + 32'd4;
        miss      = res_alias
                    || (res_br
                        && ((act_next != bp.i_res_pred_target)
                            || (bp.i_res_taken != bp.i_res_pred_taken)));
    end

    // Next table state: train on branches, drop aliased non-branches
    always_comb begin
        for (int i = 0; i < N; i++) begin
            valid_d[i] = valid_q[i];
            tag_d[i]   = tag_q[i];
            tgt_d[i]   = tgt_q[i];
            ctr_d[i]   = ctr_q[i];
        end
        if (res_br) begin
            if (r_hit) begin
                if (bp.i_res_taken) begin
                    tgt_d[r_idx] = bp.i_res_target;
                    if (ctr_q[r_idx] != 2'b11)
                        ctr_d[r_idx] = ctr_q[r_idx] + 2'd1;
                end else if (ctr_q[r_idx] != 2'b00) begin
                    ctr_d[r_idx] = ctr_q[r_idx] - 2'd1;
                end
            end else if (bp.i_res_taken) begin
                valid_d[r_idx] = 1'b1;
                tag_d[r_idx]   = r_tag;
                tgt_d[r_idx]   = bp.i_res_target;
                ctr_d[r_idx]   = 2'b10;
            end
        end else if (res_alias && r_hit) begin
            valid_d[r_idx] = 1'b0;
        end
    end

    // Next pulse/redirect and saturating statistics
    always_comb begin
        mispredict_d = miss;
        redirect_d   = miss ? act_next : redirect_q;
        branch_cnt_d = branch_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (res_br && !(&branch_cnt_q))
            branch_cnt_d = branch_cnt_q + 1'b1;
        if (miss && !(&miss_cnt_q))
            miss_cnt_d = miss_cnt_q + 1'b1;
    end

    // State registers; reset leaves counters weakly not-taken
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= 2'b01;
            end
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                valid_q[i] <= valid_d[i];
                tag_q[i]   <= tag_d[i];
                tgt_q[i]   <= tgt_d[i];
                ctr_q[i]   <= ctr_d[i];
            end
            mispredict_q <= mispredict_d;
            redirect_q   <= redirect_d;
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign bp.o_mispredict  = mispredict_q;
    assign bp.o_redirect_pc = redirect_q;
    assign bp.o_branch_cnt  = branch_cnt_q;
    assign bp.o_miss_cnt    = miss_cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: reference model of the BTB
// checked every cycle, plus literal anchor checks.
module tb_branch_predictor;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    bit   chk_en;

    branch_predictor_if #(.CNT_W(16)) bp ();

    branch_predictor #(.INDEX_W(6), .CNT_W(16)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bp      (bp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one slot per index, remembering the full word
    // address of its owner and a 0..3 confidence level.
    typedef struct {
        bit          v;
        bit [31:0]   pc;
        bit [31:0]   tgt;
        int          conf;
    } ent_t;

    ent_t      m_ent [64];
    bit        m_mis;
    bit [31:0] m_red;
    int        m_br;
    int        m_miss;

    function automatic int slot(input bit [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic bit owns(input bit [31:0] pc);
        ent_t e;
        e = m_ent[slot(pc)];
        return e.v && ((e.pc >> 2) == (pc >> 2));
    endfunction

    function automatic void m_reset();
        foreach (m_ent[i]) begin
            m_ent[i].v    = 0;
            m_ent[i].pc   = 0;
            m_ent[i].tgt  = 0;
            m_ent[i].conf = 1;
        end
        m_mis  = 0;
        m_red  = 0;
        m_br   = 0;
        m_miss = 0;
    endfunction

    function automatic void m_step();
        bit        is_miss;
        bit [31:0] nxt;
        int        s;
        is_miss = 0;
        nxt     = bp.i_res_pc + 32'd4;
        s       = slot(bp.i_res_pc);
        if (bp.i_res_valid && bp.i_res_is_branch) begin
            if (bp.i_res_taken) nxt = bp.i_res_target;
            is_miss = (nxt != bp.i_res_pred_target)
                      || (bp.i_res_taken != bp.i_res_pred_taken);
            if (m_br < 65535) m_br++;
            if (owns(bp.i_res_pc)) begin
                if (bp.i_res_taken) begin
                    m_ent[s].tgt  = bp.i_res_target;
                    m_ent[s].conf = (m_ent[s].conf < 3) ? m_ent[s].conf + 1 : 3;
                end else begin
                    m_ent[s].conf = (m_ent[s].conf > 0) ? m_ent[s].conf - 1 : 0;
                end
            end else if (bp.i_res_taken) begin
                m_ent[s].v    = 1;
                m_ent[s].pc   = bp.i_res_pc;
                m_ent[s].tgt  = bp.i_res_target;
                m_ent[s].conf = 2;
            end
        end else if (bp.i_res_valid && bp.i_res_pred_taken) begin
            is_miss = 1;
            if (owns(bp.i_res_pc)) m_ent[s].v = 0;
        end
        m_mis = is_miss;
        if (is_miss) begin
            m_red = nxt;
            if (m_miss < 65535) m_miss++;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_reset();
        else        m_step();
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            bit        pt;
            bit [31:0] ptg;
            pt  = owns(bp.i_pc) && (m_ent[slot(bp.i_pc)].conf >= 2);
            ptg = pt ? m_ent[slot(bp.i_pc)].tgt : bp.i_pc + 32'd4;
            chk("pred_taken", {31'd0, bp.o_pred_taken}, {31'd0, pt});
            chk("pred_target", bp.o_pred_target, ptg);
            chk("mispredict", {31'd0, bp.o_mispredict}, {31'd0, m_mis});
            if (m_mis) chk("redirect_pc", bp.o_redirect_pc, m_red);
            chk("branch_cnt", {16'd0, bp.o_branch_cnt}, m_br);
            chk("miss_cnt", {16'd0, bp.o_miss_cnt}, m_miss);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic res(input logic br, input logic [31:0] pc,
                       input logic tk, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptg);
        bp.i_res_valid       = 1'b1;
        bp.i_res_is_branch   = br;
        bp.i_res_pc          = pc;
        bp.i_res_taken       = tk;
        bp.i_res_target      = tgt;
        bp.i_res_pred_taken  = pt;
        bp.i_res_pred_target = ptg;
        step();
        bp.i_res_valid       = 1'b0;
    endtask

    task automatic lit(input string name, input logic pt,
                       input logic [31:0] ptg, input logic mis,
                       input logic [31:0] red, input int br, input int ms);
        chk({name, "_pt"}, {31'd0, bp.o_pred_taken}, {31'd0, pt});
        chk({name, "_ptg"}, bp.o_pred_target, ptg);
        chk({name, "_mis"}, {31'd0, bp.o_mispredict}, {31'd0, mis});
        if (mis) chk({name, "_red"}, bp.o_redirect_pc, red);
        chk({name, "_br"}, {16'd0, bp.o_branch_cnt}, br);
        chk({name, "_miss"}, {16'd0, bp.o_miss_cnt}, ms);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        chk_en = 0;
        rst_n  = 1'b0;
        bp.i_pc              = 32'h40;
        bp.i_res_valid       = 1'b0;
        bp.i_res_is_branch   = 1'b0;
        bp.i_res_pc          = '0;
        bp.i_res_taken       = 1'b0;
        bp.i_res_target      = '0;
        bp.i_res_pred_taken  = 1'b0;
        bp.i_res_pred_target = '0;
        repeat (2) step();
        rst_n  = 1'b1;
        chk_en = 1;
        @(negedge clk);
        lit("reset", 0, 32'h44, 0, 0, 0, 0);

        step();
        res(1, 32'h40, 1, 32'h100, 0, 32'h44);
        @(negedge clk);
        lit("alloc", 1, 32'h100, 1, 32'h100, 1, 1);

        step();
        repeat (3) res(1, 32'h40, 1, 32'h100, 1, 32'h100);
        @(negedge clk);
        lit("sat", 1, 32'h100, 0, 0, 4, 1);

        step();
        res(1, 32'h40, 0, 32'h100, 1, 32'h100);
        @(negedge clk);
        lit("nt1", 1, 32'h100, 1, 32'h44, 5, 2);

        step();
        res(1, 32'h40, 0, 32'h100, 1, 32'h100);
        @(negedge clk);
        lit("nt2", 0, 32'h44, 1, 32'h44, 6, 3);

        step();
        res(1, 32'h40, 1, 32'h100, 0, 32'h44);
        bp.i_pc = 32'h140;
        @(negedge clk);
        lit("alias_pc", 0, 32'h144, 1, 32'h100, 7, 4);

        step();
        bp.i_pc = 32'h40;
        res(0, 32'h40, 0, 32'h0, 1, 32'h100);
        @(negedge clk);
        lit("nonbr", 0, 32'h44, 1, 32'h44, 7, 5);

        step();
        bp.i_pc = 32'hFFFF_FFFC;
        res(1, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0);
        @(negedge clk);
        lit("wrap", 0, 32'h0, 0, 0, 8, 5);

        step();
        bp.i_pc = 32'h80;
        bp.i_res_valid       = 1'b1;
        bp.i_res_is_branch   = 1'b1;
        bp.i_res_pc          = 32'h80;
        bp.i_res_taken       = 1'b1;
        bp.i_res_target      = 32'h200;
        bp.i_res_pred_taken  = 1'b0;
        bp.i_res_pred_target = 32'h84;
        @(negedge clk);
        lit("same_pre", 0, 32'h84, 0, 0, 8, 5);
        step();
        bp.i_res_valid = 1'b0;
        @(negedge clk);
        lit("same_post", 1, 32'h200, 1, 32'h200, 9, 6);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] pc;
            pc = 32'h1000 + 32'(i % 8) * 32'h44;
            bp.i_pc = pc;
            res(1, pc, logic'(((i / 8) != 1)), pc + 32'h80,
                logic'(i[0]), pc + 32'h4);
        end
        step();

        bp.i_pc = 32'h80;
        res(1, 32'h80, 1, 32'h200, 1, 32'h200);
        bp.i_res_valid       = 1'b1;
        bp.i_res_is_branch   = 1'b1;
        bp.i_res_pc          = 32'h40;
        bp.i_res_taken       = 1'b1;
        bp.i_res_target      = 32'h300;
        bp.i_res_pred_taken  = 1'b0;
        bp.i_res_pred_target = 32'h44;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        step();
        bp.i_res_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        lit("rst_mid", 0, 32'h84, 0, 0, 0, 0);
        step();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
